// File: rtl/comp_mult_acc.sv
// rtl/comp_mult_acc.sv - complex multiply-accumulate stage: sums {xr,yr} beats per frame.
// Optional build macro COMP_MULT_ACC_SAT_EN selects saturating accumulation instead of wrap.
module comp_mult_acc #(
    parameter int DWIDTH  = 8,
    parameter int ACC_LEN = 4,
    parameter int OWIDTH  = 20
) (
    input  logic                               clk,
    input  logic                               sw_rst,
    input  logic                               in_val,
    output logic                               in_rdy,
    input  logic [4*(DWIDTH+1)-1:0]            in_data,
    input  logic                               in_last,
    output logic                               out_val,
    input  logic                               out_rdy,
    output logic [2*OWIDTH-1:0]                out_data,
    output logic [$clog2(ACC_LEN+1)-1:0]       out_cnt,
    output logic                               out_ovf
);

    localparam int IW = 2*(DWIDTH+1);
    localparam int SW = OWIDTH+1;
    localparam int CW = $clog2(ACC_LEN+1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                    r_state;
    logic                      r_in_rdy;
    logic                      r_out_val;
    logic signed [OWIDTH-1:0]  r_xacc;
    logic signed [OWIDTH-1:0]  r_yacc;
    logic [CW-1:0]             r_cnt;
    logic                      r_ovf;
    logic [OWIDTH-1:0]         r_xs;
    logic [OWIDTH-1:0]         r_ys;
    logic [CW-1:0]             r_out_cnt;
    logic                      r_out_ovf;

    logic signed [IW-1:0]      w_xr;
    logic signed [IW-1:0]      w_yr;
    logic signed [SW-1:0]      w_xsum;
    logic signed [SW-1:0]      w_ysum;
    logic                      w_xovf;
    logic                      w_yovf;
    logic                      w_ovf_next;
    logic [OWIDTH-1:0]         w_xnext;
    logic [OWIDTH-1:0]         w_ynext;
    logic                      w_accept;
    logic                      w_final;
    logic [CW-1:0]             w_cnt_next;

    // An (OWIDTH+1)-bit sum whose top two bits disagree no longer fits OWIDTH bits.
    function automatic logic [OWIDTH-1:0] fold(input logic [SW-1:0] s);
`ifdef COMP_MULT_ACC_SAT_EN
        if (s[SW-1] != s[SW-2])
            fold = s[SW-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
        else
            fold = s[OWIDTH-1:0];
`else
        fold = s[OWIDTH-1:0];
`endif
    endfunction

    assign w_xr       = in_data[2*IW-1:IW];
    assign w_yr       = in_data[IW-1:0];
    assign w_xsum     = SW'(r_xacc) + SW'(w_xr);
    assign w_ysum     = SW'(r_yacc) + SW'(w_yr);
    assign w_xovf     = w_xsum[SW-1] ^ w_xsum[SW-2];
    assign w_yovf     = w_ysum[SW-1] ^ w_ysum[SW-2];
    assign w_ovf_next = r_ovf | w_xovf | w_yovf;
    assign w_xnext    = fold(w_xsum);
    assign w_ynext    = fold(w_ysum);
    assign w_accept   = in_val & r_in_rdy;
    assign w_final    = in_last | (r_cnt == CW'(ACC_LEN-1));
    assign w_cnt_next = r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_state   <= ST_ACC;
            r_in_rdy  <= 1'b1;
            r_out_val <= 1'b0;
            r_xacc    <= '0;
            r_yacc    <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_xs      <= '0;
            r_ys      <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_xacc <= w_xnext;
                        r_yacc <= w_ynext;
                        r_cnt  <= w_cnt_next;
                        r_ovf  <= w_ovf_next;
                        if (w_final) begin
                            r_state   <= ST_OUT;
                            r_in_rdy  <= 1'b0;
                            r_out_val <= 1'b1;
                            r_xs      <= w_xnext;
                            r_ys      <= w_ynext;
                            r_out_cnt <= w_cnt_next;
                            r_out_ovf <= w_ovf_next;
                        end
                    end
                end
                ST_OUT: begin
                    // Clearing here gives the one-cycle bubble before the next frame.
                    if (out_rdy) begin
                        r_state   <= ST_ACC;
                        r_in_rdy  <= 1'b1;
                        r_out_val <= 1'b0;
                        r_xacc    <= '0;
                        r_yacc    <= '0;
                        r_cnt     <= '0;
                        r_ovf     <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_ACC;
                    r_in_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign in_rdy   = r_in_rdy;
    assign out_val  = r_out_val;
    assign out_data = {r_xs, r_ys};
    assign out_cnt  = r_out_cnt;
    assign out_ovf  = r_out_ovf;

endmodule

// File: tb/tb_comp_mult_acc.sv
// tb/tb_comp_mult_acc.sv - randomized and directed check of comp_mult_acc against an integer model.
module tb_comp_mult_acc;

    localparam int DW  = 8;
    localparam int AL  = 4;
    localparam int IW  = 2*(DW+1);
    localparam int OWA = 20;
    localparam int OWB = 18;
    localparam int CW  = $clog2(AL+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              sw_rst;
    logic              in_val;
    logic              in_last;
    logic              out_rdy;
    logic [2*IW-1:0]   in_data;

    logic              a_in_rdy, a_out_val, a_out_ovf;
    logic [2*OWA-1:0]  a_out_data;
    logic [CW-1:0]     a_out_cnt;
    logic              b_in_rdy, b_out_val, b_out_ovf;
    logic [2*OWB-1:0]  b_out_data;
    logic [CW-1:0]     b_out_cnt;

    comp_mult_acc #(.DWIDTH(DW), .ACC_LEN(AL), .OWIDTH(OWA)) u_dut_a (
        .clk(clk), .sw_rst(sw_rst), .in_val(in_val), .in_rdy(a_in_rdy),
        .in_data(in_data), .in_last(in_last), .out_val(a_out_val), .out_rdy(out_rdy),
        .out_data(a_out_data), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
    );

    comp_mult_acc #(.DWIDTH(DW), .ACC_LEN(AL), .OWIDTH(OWB)) u_dut_b (
        .clk(clk), .sw_rst(sw_rst), .in_val(in_val), .in_rdy(b_in_rdy),
        .in_data(in_data), .in_last(in_last), .out_val(b_out_val), .out_rdy(out_rdy),
        .out_data(b_out_data), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: frame sums as plain integers, index 0 = 20-bit, 1 = 18-bit instance.
    bit     m_pend;
    int     m_cnt;
    longint m_acc [2][2];
    bit     m_ovf [2];
    longint m_out [2][2];
    int     m_out_cnt;
    bit     m_out_ovf [2];

    function automatic longint hi_of(input int ow);
        return (longint'(1) <<< (ow-1)) - 1;
    endfunction

    function automatic longint lo_of(input int ow);
        return -(longint'(1) <<< (ow-1));
    endfunction

    function automatic bit ovf_of(input longint acc, input longint v, input int ow);
        return (acc + v > hi_of(ow)) || (acc + v < lo_of(ow));
    endfunction

    function automatic longint accum(input longint acc, input longint v, input int ow);
        longint s;
        s = acc + v;
`ifdef COMP_MULT_ACC_SAT_EN
        if (s > hi_of(ow)) return hi_of(ow);
        if (s < lo_of(ow)) return lo_of(ow);
`else
        if (s > hi_of(ow)) return s - (longint'(1) <<< ow);
        if (s < lo_of(ow)) return s + (longint'(1) <<< ow);
`endif
        return s;
    endfunction

    task automatic model_clear_frame();
        m_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i][0] = 0;
            m_acc[i][1] = 0;
            m_ovf[i]    = 1'b0;
        end
    endtask

    task automatic model_step(input bit rst, input bit val, input bit last,
                              input longint xr, input longint yr, input bit ordy);
        int ow;
        if (rst) begin
            m_pend    = 1'b0;
            m_out_cnt = 0;
            model_clear_frame();
            for (int i = 0; i < 2; i++) begin
                m_out[i][0]  = 0;
                m_out[i][1]  = 0;
                m_out_ovf[i] = 1'b0;
            end
        end else if (m_pend) begin
            if (ordy) begin
                m_pend = 1'b0;
                model_clear_frame();
            end
        end else if (val) begin
            for (int i = 0; i < 2; i++) begin
                ow = (i == 0) ? OWA : OWB;
                if (ovf_of(m_acc[i][0], xr, ow) || ovf_of(m_acc[i][1], yr, ow)) m_ovf[i] = 1'b1;
                m_acc[i][0] = accum(m_acc[i][0], xr, ow);
                m_acc[i][1] = accum(m_acc[i][1], yr, ow);
            end
            m_cnt++;
            if (last || m_cnt == AL) begin
                m_pend    = 1'b1;
                m_out_cnt = m_cnt;
                for (int i = 0; i < 2; i++) begin
                    m_out[i][0]  = m_acc[i][0];
                    m_out[i][1]  = m_acc[i][1];
                    m_out_ovf[i] = m_ovf[i];
                end
            end
        end
    endtask

    function automatic longint a_xs(); return longint'($signed(a_out_data[2*OWA-1:OWA])); endfunction
    function automatic longint a_ys(); return longint'($signed(a_out_data[OWA-1:0]));     endfunction
    function automatic longint b_xs(); return longint'($signed(b_out_data[2*OWB-1:OWB])); endfunction
    function automatic longint b_ys(); return longint'($signed(b_out_data[OWB-1:0]));     endfunction

    task automatic compare_outputs();
        check("a_in_rdy", a_in_rdy, !m_pend);
        check("a_out_val", a_out_val, m_pend);
        check("b_in_rdy", b_in_rdy, !m_pend);
        check("b_out_val", b_out_val, m_pend);
        if (m_pend) begin
            check("a_xs", a_xs(), m_out[0][0]);
            check("a_ys", a_ys(), m_out[0][1]);
            check("a_cnt", a_out_cnt, m_out_cnt);
            check("a_ovf", a_out_ovf, m_out_ovf[0]);
            check("b_xs", b_xs(), m_out[1][0]);
            check("b_ys", b_ys(), m_out[1][1]);
            check("b_cnt", b_out_cnt, m_out_cnt);
            check("b_ovf", b_out_ovf, m_out_ovf[1]);
        end
    endtask

    // One clock: drive inputs, advance model, sample shortly after the edge.
    task automatic cyc(input bit rst, input bit val, input bit last,
                       input longint xr, input longint yr, input bit ordy);
        logic [IW-1:0] xv, yv;
        xv      = xr[IW-1:0];
        yv      = yr[IW-1:0];
        sw_rst  = rst;
        in_val  = val;
        in_last = last;
        in_data = {xv, yv};
        out_rdy = ordy;
        model_step(rst, val, last, xr, yr, ordy);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    function automatic longint rnd_val();
        logic [IW-1:0] r;
        r = IW'($urandom);
        if ($urandom_range(0, 3) == 0) r = {r[IW-1], r[IW-1], 2'b11 ^ {2{r[IW-1]}}, r[IW-5:0]};
        return longint'($signed(r));
    endfunction

    initial begin
        sw_rst  = 1'b1;
        in_val  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        in_data = '0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_a_data", a_out_data, 0);
        check("rst_a_cnt", a_out_cnt, 0);
        check("rst_a_ovf", a_out_ovf, 0);
        check("rst_in_rdy", a_in_rdy, 1);

        // Four equal beats, immediate drain: one-cycle ready bubble.
        for (int i = 0; i < AL; i++) cyc(0, 1, 0, 100, -50, 1);
        check("t1_val", a_out_val, 1);
        check("t1_xs", a_xs(), 400);
        check("t1_ys", a_ys(), -200);
        check("t1_cnt", a_out_cnt, 4);
        check("t1_ovf", a_out_ovf, 0);
        check("t1_rdy_lo", a_in_rdy, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("t1_rdy_back", a_in_rdy, 1);

        // Early termination on in_last.
        cyc(0, 1, 0, 3, 5, 1);
        cyc(0, 1, 1, -7, 1, 1);
        check("t2_xs", a_xs(), -4);
        check("t2_ys", a_ys(), 6);
        check("t2_cnt", a_out_cnt, 2);
        cyc(0, 0, 0, 0, 0, 1);

        // Backpressure held for ten cycles while input keeps offering data.
        for (int i = 0; i < AL; i++) cyc(0, 1, 0, 11 + i, -3, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 999, 999, 0);
        check("t3_xs", a_xs(), 50);
        cyc(0, 1, 0, 999, 999, 1);
        cyc(0, 1, 1, 2, 2, 1);
        check("t3_fresh_xs", a_xs(), 2);
        cyc(0, 0, 0, 0, 0, 1);

        // Overflow on the narrow instance.
        for (int i = 0; i < AL; i++) cyc(0, 1, 0, 32768, 0, 1);
        check("t4_a_xs", a_xs(), 131072);
        check("t4_a_ovf", a_out_ovf, 0);
`ifdef COMP_MULT_ACC_SAT_EN
        check("t4_b_xs", b_xs(), 131071);
`else
        check("t4_b_xs", b_xs(), -131072);
`endif
        check("t4_b_ovf", b_out_ovf, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Reset mid-frame discards the partial sum.
        cyc(0, 1, 0, 9, 0, 1);
        cyc(0, 1, 0, 9, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < AL; i++) cyc(0, 1, 0, 1, -1, 0);
        check("t5_xs", a_xs(), 4);
        check("t5_ys", a_ys(), -4);
        check("t5_cnt", a_out_cnt, 4);
        cyc(0, 0, 0, 0, 0, 1);

        // in_last without in_val is ignored; single-term frame.
        cyc(0, 0, 1, 77, 77, 1);
        cyc(0, 0, 1, 77, 77, 1);
        cyc(0, 1, 1, -5, 7, 1);
        check("t6_xs", a_xs(), -5);
        check("t6_ys", a_ys(), 7);
        check("t6_cnt", a_out_cnt, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 3) == 0,
                rnd_val(), rnd_val(),
                $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
